// File: rtl/ahb_sram_slave.sv
// ahb_sram_slave: AHB responder over a word-wide SRAM with programmable wait states,
// byte-lane writes and the two-cycle ERROR response for misaligned or oversized transfers.
module ahb_sram_slave #(
  parameter int MEM_AW = 10,
  parameter int WAIT_STATES = 0
) (
  input  logic        hclk,
  input  logic        hreset_n,
  input  logic        hsel,
  input  logic [31:0] haddr,
  input  logic [1:0]  htrans,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [2:0]  hburst,
  input  logic [3:0]  hprot,
  input  logic        hmastlock,
  input  logic [31:0] hwdata,
  input  logic        hready,
  output logic [31:0] hrdata,
  output logic        hreadyout,
  output logic [1:0]  hresp
);
  typedef enum logic [2:0] {IDLE, WAIT, DATA, ERR1, ERR2} state_t;
  state_t state;
  logic [31:0] mem [2**MEM_AW];
  logic [MEM_AW-1:0] a_q, a_d;
  logic [1:0] off_q;
  logic [2:0] size_q;
  logic wr_q, smp, bad, we, unused;
  logic [3:0] cnt, be;
  logic [31:0] rd_fwd;
  assign a_d = haddr[MEM_AW+1:2];
  assign smp = hsel & hready & htrans[1] & (state == IDLE | state == DATA | state == ERR2);
  assign bad = hsize > 3'd2 | (hsize == 3'd1 & haddr[0]) | (hsize == 3'd2 & haddr[1:0] != 2'd0);
  assign we = state == DATA & wr_q;
  assign be = size_q == 3'd0 ? 4'b0001 << off_q : size_q == 3'd1 ? (off_q[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign unused = ^{htrans[0], hburst, hprot, hmastlock, haddr[31:MEM_AW+2]};
  // A read sampled while a write to the same word completes sees the new bytes.
  always_comb begin
    rd_fwd = mem[a_d];
    for (int i = 0; i < 4; i++)
      if (we & be[i] & a_q == a_d) rd_fwd[8*i +: 8] = hwdata[8*i +: 8];
  end
  always_ff @(posedge hclk)
    for (int i = 0; i < 4; i++)
      if (we & be[i]) mem[a_q][8*i +: 8] <= hwdata[8*i +: 8];
  always_ff @(posedge hclk or negedge hreset_n)
    if (!hreset_n) begin
      state <= IDLE;
      cnt <= '0;
      a_q <= '0;
      off_q <= '0;
      size_q <= '0;
      wr_q <= 1'b0;
      hreadyout <= 1'b1;
      hresp <= 2'b00;
      hrdata <= '0;
    end else if (smp) begin
      a_q <= a_d;
      off_q <= haddr[1:0];
      size_q <= hsize;
      wr_q <= hwrite;
      cnt <= WAIT_STATES > 0 ? 4'(WAIT_STATES - 1) : 4'd0;
      state <= bad ? ERR1 : WAIT_STATES > 0 ? WAIT : DATA;
      hreadyout <= !bad && WAIT_STATES == 0;
      hresp <= {1'b0, bad};
      hrdata <= !bad && WAIT_STATES == 0 && !hwrite ? rd_fwd : '0;
    end else if (state == WAIT) begin
      cnt <= cnt - 4'd1;
      state <= cnt == 4'd0 ? DATA : WAIT;
      hreadyout <= cnt == 4'd0;
      hrdata <= cnt == 4'd0 && !wr_q ? mem[a_q] : '0;
    end else if (state == ERR1) begin
      state <= ERR2;
      hreadyout <= 1'b1;
      hresp <= 2'b01;
    end else begin
      state <= IDLE;
      hreadyout <= 1'b1;
      hresp <= 2'b00;
      hrdata <= '0;
    end
endmodule

// File: tb/tb_ahb_sram_slave.sv
// tb_ahb_sram_slave: directed AHB traffic into three responders (0, 2 and 3 wait states)
// with an in-order scoreboard checked by a negedge bus monitor.
module tb_ahb_sram_slave;
  logic hclk = 0, hreset_n = 0, hsel = 0, hwrite = 0, hmastlock = 0;
  logic [31:0] haddr = 0, hwdata = 0;
  logic [1:0] htrans = 0;
  logic [2:0] hsize = 0, hburst = 0;
  logic [3:0] hprot = 0;
  logic hready;
  logic [31:0] rd [3];
  logic rdy [3];
  logic [1:0] rsp [3];
  logic [2:0] hs;
  int dsel = 0;
  int checks = 0, errors = 0;
  typedef struct {logic [31:0] data; logic [1:0] resp; int waits;} exp_t;
  exp_t exp_q[$];
  logic act = 0;
  int nw = 0;
  always #5 hclk = ~hclk;
  assign hready = rdy[dsel];
  assign hs = {hsel && dsel == 2, hsel && dsel == 1, hsel && dsel == 0};
  for (genvar g = 0; g < 3; g++) begin : g_dut
    ahb_sram_slave #(.MEM_AW(10), .WAIT_STATES(g == 0 ? 0 : g + 1)) u (
      .hclk(hclk), .hreset_n(hreset_n), .hsel(hs[g]), .haddr(haddr), .htrans(htrans),
      .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hprot(hprot), .hmastlock(hmastlock),
      .hwdata(hwdata), .hready(hready), .hrdata(rd[g]), .hreadyout(rdy[g]), .hresp(rsp[g]));
  end
  function automatic void chk(string n, logic [63:0] got, logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", n, got, want);
    end
  endfunction
  always @(negedge hclk) begin
    if (!hreset_n) begin
      act = 0;
      nw = 0;
    end else begin
      if (!act) chk("idle", {rd[dsel], rsp[dsel], rdy[dsel]}, {32'h0, 2'b00, 1'b1});
      else if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL orphan data phase got none want queued entry");
      end else if (!hready) begin
        nw++;
        chk("wait", {rd[dsel], rsp[dsel]}, {32'h0, exp_q[0].resp});
      end else begin
        chk("data", {rd[dsel], rsp[dsel]}, {exp_q[0].data, exp_q[0].resp});
        chk("waits", nw, exp_q[0].waits);
        void'(exp_q.pop_front());
        nw = 0;
      end
      if (hready) act = hsel & htrans[1];
    end
  end
  task automatic beat(input logic [1:0] tr, input logic wr, input logic [2:0] sz,
                      input logic [31:0] a, wd, ed, input logic [1:0] er, input int ew);
    int n = 0;
    hsel = 1;
    htrans = tr;
    hwrite = wr;
    hsize = sz;
    haddr = a;
    if (tr[1]) exp_q.push_back('{ed, er, ew});
    @(negedge hclk);
    while (!hready && n < 50) begin
      n++;
      @(negedge hclk);
    end
    if (!hready) begin
      errors++;
      $display("FAIL timeout addr %h got hready 0 want 1", a);
    end
    @(posedge hclk);
    #1 hwdata = wd;
  endtask
  task automatic w(input logic [31:0] a, d, input logic [2:0] sz, input int ws);
    beat(2'b10, 1'b1, sz, a, d, 32'h0, 2'b00, ws);
  endtask
  task automatic r(input logic [1:0] tr, input logic [31:0] a, e, input int ws);
    beat(tr, 1'b0, 3'd2, a, 32'h0, e, 2'b00, ws);
  endtask
  task automatic idle();
    beat(2'b00, 1'b0, 3'd0, 32'h0, 32'h0, 32'h0, 2'b00, 0);
    hsel = 0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog got no finish want finish");
    $fatal(1);
  end
  initial begin
    repeat (2) @(posedge hclk);
    #1 hreset_n = 1;
    @(posedge hclk);
    #1;
    w(32'h4, 32'hDEADBEEF, 3'd2, 0);
    r(2'b10, 32'h4, 32'hDEADBEEF, 0);
    w(32'h8, 32'h0, 3'd2, 0);
    w(32'hA, 32'h00AB0000, 3'd0, 0);
    w(32'h8, 32'h00001234, 3'd1, 0);
    r(2'b10, 32'h8, 32'h00AB1234, 0);
    w(32'h44, 32'h13579BDF, 3'd2, 0);
    w(32'h40, 32'h5A5A5A5A, 3'd2, 0);
    r(2'b10, 32'h40, 32'h5A5A5A5A, 0);
    beat(2'b10, 1'b0, 3'd2, 32'h2, 32'h0, 32'h0, 2'b01, 1);
    idle();
    beat(2'b10, 1'b1, 3'd3, 32'h44, 32'hFFFFFFFF, 32'h0, 2'b01, 1);
    idle();
    r(2'b10, 32'h44, 32'h13579BDF, 0);
    idle();
    dsel = 1;
    for (int i = 0; i < 4; i++) w(32'h20 + 4 * i, 32'hC0DE0020 + 4 * i, 3'd2, 2);
    hburst = 3'b011;
    r(2'b10, 32'h20, 32'hC0DE0020, 2);
    r(2'b11, 32'h24, 32'hC0DE0024, 2);
    r(2'b01, 32'h28, 32'h0, 0);
    r(2'b11, 32'h28, 32'hC0DE0028, 2);
    r(2'b11, 32'h2C, 32'hC0DE002C, 2);
    idle();
    hburst = 3'b000;
    dsel = 2;
    w(32'h10, 32'h11111111, 3'd2, 3);
    idle();
    w(32'h10, 32'h22222222, 3'd2, 3);
    @(negedge hclk);
    #1 hreset_n = 0;
    #1 chk("reset_out", {rd[2], rsp[2], rdy[2]}, {32'h0, 2'b00, 1'b1});
    exp_q.delete();
    htrans = 0;
    hsel = 0;
    @(posedge hclk);
    @(negedge hclk);
    #1 hreset_n = 1;
    @(posedge hclk);
    #1;
    r(2'b10, 32'h10, 32'h11111111, 3);
    idle();
    repeat (2) @(posedge hclk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ahb_sram_slave.md
Name: ahb_sram_slave

Overview:
AHB responder (slave) backed by an internal word-organised memory; the target end of the bus driven by ahb_master through the master multiplexor and selected by address_decoder.
Accepts pipelined address/data-phase transfers, inserts a programmable number of wait states, supports byte/halfword/word writes with lane masking, and returns the two-cycle ERROR response for illegal transfers.
Drives hrdata/hreadyout/hresp into the slave-side response multiplexor.

Parameters:
MEM_AW, 10, word-address bits; memory depth 2^MEM_AW 32-bit words; byte offset taken from haddr[MEM_AW+1:0], upper bits ignored (decoder already selected).
WAIT_STATES, 0, hreadyout-low cycles inserted before completion of every OKAY read or write data phase (0..15).

Ports:
hclk  input  1  bus clock, all state on rising edge
hreset_n  input  1  asynchronous active-low reset
hsel  input  1  slave select from address_decoder
haddr  input  32  transfer address (address phase)
htrans  input  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
hwrite  input  1  1 write, 0 read
hsize  input  3  0 byte, 1 halfword, 2 word; >2 illegal
hburst  input  3  burst type; accepted, not used for addressing
hprot  input  4  protection; ignored
hmastlock  input  1  locked sequence; ignored
hwdata  input  32  write data (data phase)
hready  input  1  global bus ready (muxed hreadyout)
hrdata  output  32  read data, valid when hreadyout=1 in read data phase
hreadyout  output  1  slave ready
hresp  output  2  00 OKAY, 01 ERROR (RETRY/SPLIT never driven)

Behaviour:
- Reset (async, hreset_n=0): hreadyout=1, hresp=00, hrdata=0, FSM=IDLE, wait counter=0, latched phase cleared. Memory contents not reset. Reset mid-transfer aborts it; no memory write occurs.
- Address phase sampled on rising edge when hsel & hready & htrans[1]; latch addr, hwrite, hsize; legality check at sample time.
- IDLE/BUSY, or hsel=0, with hready=1: no transfer; next cycle hreadyout=1, hresp=00 (zero-wait OKAY).
- Illegal: hsize>2; hsize=1 & haddr[0]=1; hsize=2 & haddr[1:0]!=0.
- FSM states: IDLE, WAIT, DATA, ERR1, ERR2.
  IDLE: legal sample & WAIT_STATES>0 -> WAIT (counter=WAIT_STATES-1); legal & WAIT_STATES=0 -> DATA; illegal -> ERR1.
  WAIT: hreadyout=0, hresp=00; counter decrements; at 0 -> DATA.
  DATA: hreadyout=1, hresp=00; transfer completes this cycle; new sample this edge follows IDLE rules, else -> IDLE.
  ERR1: hreadyout=0, hresp=01 -> ERR2.
  ERR2: hreadyout=1, hresp=01; no memory access; new sample allowed this edge (master normally drives IDLE).
- Back-to-back pipelining: next address phase sampled on the same edge the current data phase completes; no bubble at WAIT_STATES=0.
- Write: memory updated on the rising edge ending the DATA cycle, using hwdata on that edge. Lane mask: byte -> lane haddr[1:0]; halfword -> lanes {haddr[1],0}+0/1; word -> all four. Little-endian, lane n = bits 8n+7:8n.
- Read: hrdata = mem[latched word addr] full 32 bits in DATA cycle regardless of hsize; 0 in all other cycles. A read whose address phase overlaps a preceding write's data phase to the same word returns the newly written data.
- Wait states apply per transfer, including each SEQ beat of a burst.
- hsel dropping during own wait states has no effect; the transfer in progress completes.

Test Plan:
- Reset: hreset_n=0 mid WAIT with WAIT_STATES=3 -> hreadyout=1, hresp=00, hrdata=0 immediately; the pending write to 0x10 is not performed (subsequent read returns prior value).
- Word write/read, WAIT_STATES=0: NONSEQ write 0x0000_0004 data 0xDEADBEEF, then NONSEQ read 0x4 -> hreadyout never low; read data phase hrdata=0xDEADBEEF.
- Byte/halfword lanes: word 0x8=0x00000000; byte write 0x0000_000A data 0x00AB0000; halfword write 0x8 data 0x00001234 -> read 0x8 returns 0x00AB1234.
- Wait states, WAIT_STATES=2: INCR4 read burst 0x20..0x2C -> each beat has 2 hreadyout=0 cycles then 1 cycle hreadyout=1 with the correct word; BUSY beat inserted -> OKAY zero-wait, no advance.
- Error: word read at 0x0000_0002 -> cycle1 hreadyout=0/hresp=01, cycle2 hreadyout=1/hresp=01, hrdata=0; hsize=3 write -> same two-cycle ERROR, memory unchanged.
- Pipelined write-then-read of same address 0x40 (data 0x5A5A5A5A) back-to-back with WAIT_STATES=0 -> read returns 0x5A5A5A5A.
